// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the single-cycle RV32I core: single-step, free-run and PC breakpoint.
// cpu_en is a one-cycle pulse that gates PC, register-file and data-memory updates.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int CNT_W           = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  mode,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STEP  = 2'b01,
        RUN   = 2'b10,
        BREAK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_DIV - 1);

    state_t           state;
    logic             step_m, step_s, run_m, run_s;
    logic             deb_lvl, deb_lvl_q;
    logic [CNT_W-1:0] deb_cnt, rate_cnt;
    logic             step_req, issue, bp_hit;

    assign step_req = deb_lvl & ~deb_lvl_q;
    assign issue    = (rate_cnt == RUN_LAST);
    assign bp_hit   = bp_en && (pc == bp_addr);
    assign mode     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_m      <= 1'b0;
            step_s      <= 1'b0;
            run_m       <= 1'b0;
            run_s       <= 1'b0;
            deb_lvl     <= 1'b0;
            deb_lvl_q   <= 1'b0;
            deb_cnt     <= '0;
            rate_cnt    <= '0;
            state       <= IDLE;
            cpu_en      <= 1'b0;
            halted      <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            step_m    <= step_btn;
            step_s    <= step_m;
            run_m     <= run_sw;
            run_s     <= run_m;
            deb_lvl_q <= deb_lvl;

            // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts it.
            if (step_s == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl <= step_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (cpu_en) begin
                instr_count <= instr_count + 32'd1;
            end

            cpu_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_s) begin
                        state    <= RUN;
                        rate_cnt <= '0;
                    end else if (step_req) begin
                        state  <= STEP;
                        cpu_en <= 1'b1;
                    end
                end
                STEP: begin
                    state <= IDLE;
                end
                RUN: begin
                    if (!run_s) begin
                        state    <= IDLE;
                        rate_cnt <= '0;
                    end else if (issue) begin
                        rate_cnt <= '0;
                        if (bp_hit) begin
                            state  <= BREAK;
                            halted <= 1'b1;
                        end else begin
                            cpu_en <= 1'b1;
                        end
                    end else begin
                        rate_cnt <= rate_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (!run_s) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end else if (step_req) begin
                        state  <= STEP;
                        halted <= 1'b0;
                        cpu_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with short debounce and run divider.
// A small datapath stand-in advances pc by 4 on every cpu_en pulse when enabled.
module tb_cpu_step_controller;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_btn;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  mode;
    logic [31:0] instr_count;

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .mode       (mode),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse = 0;
    int         pb = 0;
    int         nseq = 0;
    bit         chk_spacing = 1'b0;
    bit         pc_auto = 1'b0;
    bit         prev_en = 1'b0;
    bit         saw_step = 1'b0;
    bit         done = 1'b0;
    logic [1:0] last_mode = 2'b00;
    logic [1:0] seq [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_en) begin
            check("back2back", 32'(prev_en), 32'd0);
            if (chk_spacing && last_pulse > 0) check("spacing", cyc - last_pulse, DIV);
            pulses++;
            last_pulse = cyc;
            if (pc_auto) pc = pc + 32'd4;
        end
        prev_en = cpu_en;
        if (mode == 2'b01) saw_step = 1'b1;
        if (mode != last_mode) begin
            if (nseq < 8) begin
                seq[nseq] = mode;
                nseq++;
            end
            last_mode = mode;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        cyc = 0;
        pulses = 0;
        last_pulse = 0;
        prev_en = 1'b0;
        last_mode = 2'b00;
        nseq = 0;
        saw_step = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step_btn = 1'b1;
        run_sw = 1'b1;
        bp_en = 1'b0;
        bp_addr = 32'd0;
        pc = 32'd0;

        // Reset dominates active inputs, then RUN is entered after the synchronizer.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_en", 32'(cpu_en), 32'd0);
            check("rst_mode", 32'(mode), 32'd0);
            check("rst_cnt", instr_count, 32'd0);
        end
        rst = 1'b0;
        cyc = 0;
        repeat (2) tick();
        check("rst_sync_lat", 32'(mode), 32'd0);
        tick();
        check("rst_run_entry", 32'(mode), 32'd2);

        // Bouncy step button.
        step_btn = 1'b0;
        run_sw = 1'b0;
        do_reset();
        repeat (6) tick();
        step_btn = 1'b1; tick();
        step_btn = 1'b0; tick();
        step_btn = 1'b1; tick();
        step_btn = 1'b0; tick();
        step_btn = 1'b1; repeat (3) tick();
        step_btn = 1'b0; repeat (6) tick();
        check("short_bounce", pulses, 0);
        step_btn = 1'b1;
        repeat (12) tick();
        check("step_pulses", pulses, 1);
        check("step_seen", 32'(saw_step), 32'd1);
        check("step_idle", 32'(mode), 32'd0);
        check("step_count", instr_count, 32'd1);
        step_btn = 1'b0;
        repeat (10) tick();
        check("release_nopulse", pulses, 1);

        // Free-run at the divided rate.
        do_reset();
        run_sw = 1'b1;
        chk_spacing = 1'b1;
        repeat (80) tick();
        check("run_pulses", pulses, 9);
        check("run_count", instr_count, 32'd9);
        check("run_mode", 32'(mode), 32'd2);
        run_sw = 1'b0;
        repeat (20) tick();
        chk_spacing = 1'b0;
        check("run_stop_pulses", pulses, 9);
        check("run_stop_mode", 32'(mode), 32'd0);

        // Breakpoint at 0xC.
        do_reset();
        pc = 32'd0;
        pc_auto = 1'b1;
        bp_en = 1'b1;
        bp_addr = 32'h0000_000C;
        run_sw = 1'b1;
        for (int i = 0; i < 60 && !halted; i++) tick();
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_pulses", pulses, 3);
        check("bp_mode", 32'(mode), 32'd3);
        check("bp_pc", pc, 32'h0000_000C);
        check("bp_count", instr_count, 32'd3);
        repeat (10) tick();
        check("bp_hold", pulses, 3);
        nseq = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 20 && mode != 2'b10; i++) tick();
        check("bp_seq_n", nseq, 3);
        check("bp_seq0", 32'(seq[0]), 32'd1);
        check("bp_seq1", 32'(seq[1]), 32'd0);
        check("bp_seq2", 32'(seq[2]), 32'd2);
        check("bp_step_pulses", pulses, 4);
        check("bp_step_count", instr_count, 32'd4);
        for (int i = 0; i < 12 && pulses < 5; i++) tick();
        check("bp_resume", pulses, 5);
        check("bp_resume_pc", pc, 32'h0000_0014);
        step_btn = 1'b0;
        bp_addr = pc;
        for (int i = 0; i < 20 && !halted; i++) tick();
        repeat (4) tick();
        check("bp2_halted", 32'(halted), 32'd1);
        check("bp2_pc", pc, 32'h0000_0014);

        // BREAK: run_s falls in the same cycle as step_req.
        saw_step = 1'b0;
        pb = pulses;
        step_btn = 1'b1;
        repeat (4) tick();
        run_sw = 1'b0;
        repeat (6) tick();
        check("brk_conf_mode", 32'(mode), 32'd0);
        check("brk_conf_halted", 32'(halted), 32'd0);
        check("brk_conf_pulse", pulses, pb);
        check("brk_conf_step", 32'(saw_step), 32'd0);
        step_btn = 1'b0;
        repeat (10) tick();

        // IDLE: run_s rises in the same cycle as step_req.
        saw_step = 1'b0;
        pb = pulses;
        step_btn = 1'b1;
        repeat (4) tick();
        run_sw = 1'b1;
        repeat (4) tick();
        check("idle_conf_mode", 32'(mode), 32'd2);
        check("idle_conf_step", 32'(saw_step), 32'd0);
        check("idle_conf_pulse", pulses, pb);
        run_sw = 1'b0;
        step_btn = 1'b0;
        repeat (12) tick();
        check("idle_conf_back", 32'(mode), 32'd0);
        check("idle_conf_pulse2", pulses, pb);

        // instr_count wrap.
        pc_auto = 1'b0;
        bp_en = 1'b0;
        force dut.instr_count = 32'hFFFF_FFFF;
        tick();
        release dut.instr_count;
        tick();
        check("wrap_pre", instr_count, 32'hFFFF_FFFF);
        pb = pulses;
        step_btn = 1'b1;
        repeat (12) tick();
        check("wrap_pulse", pulses, pb + 1);
        check("wrap_count", instr_count, 32'h0000_0000);
        step_btn = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        done = 1'b1;
        $finish;
    end

endmodule
